// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Samples the PC, runs a single
// outstanding read to instruction memory, buffers returned words in a
// 2-entry prefetch FIFO and stalls the PC until a fetch is accepted.
module fetch_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_addr,
  input  logic             flush,
  output logic             stahp,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] ir,
  output logic             ir_valid,
  input  logic             ir_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_mem_req;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_has_room;
  logic w_push;
  logic w_pop;

  // A new fetch may only start while a buffer slot is guaranteed free.
  assign w_has_room = (r_count < CNT_W'(DEPTH));
  // Only words returned for a live (non-dropped) request enter the buffer.
  assign w_push     = (r_state == S_REQ) & mem_ack & ~flush;
  assign w_pop      = (r_count != '0) & ir_ready;

  assign stahp    = ~(reset & (r_state == S_IDLE) & w_has_room & ~flush);
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign ir       = r_buf[r_rd_ptr];
  assign ir_valid = (r_count != '0);

  // Fetch handshake FSM: issue one request at a time, drop it on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush && w_has_room) begin
            r_mem_addr <= pc_addr;
            r_mem_req  <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end else if (flush) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Prefetch FIFO; a redirect empties it regardless of push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_buf[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= mem_rdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that consumes the program counter's `out` value and turns it into instruction words for decode. It samples the PC address, runs a single-outstanding read handshake to instruction memory, and holds returned words in a 2-entry prefetch buffer. It drives `stahp` back to the PC so the PC advances exactly once per accepted fetch. `flush` marks a PC redirect and discards all stale fetch state.

## Interface

Parameters:
- `WIDTH`, 16, address and instruction word width.
- `DEPTH`, 2, prefetch buffer entries; fixed at 2, other values unsupported.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_addr`  in  WIDTH  current PC value, from PC `out`.
- `flush`  in  1  redirect; asserted in the same cycle the PC `pcdrive` is asserted.
- `stahp`  out  1  stall to PC; low means the PC may advance this cycle.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  WIDTH  read address; stable while `mem_req` is high.
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  WIDTH  instruction word.
- `ir`  out  WIDTH  head-of-buffer instruction.
- `ir_valid`  out  1  `ir` holds a valid instruction.
- `ir_ready`  in  1  decode accepts `ir`; a pop occurs when `ir_valid & ir_ready`.

## Operation

- **State machine:**
  - IDLE (no request in flight).
  - REQ (request in flight, result kept).
  - DROP (request in flight, result to be discarded).
- **IDLE:**
  - `flush` clears the buffer and the FSM stays in IDLE.
  - Otherwise, if the registered `count < 2`, capture `pc_addr` into `mem_addr` and go to REQ. This is the only cycle where `stahp=0`.
  - Otherwise (`count==2`) hold in IDLE with `stahp=1`.
- **REQ:**
  - `mem_req=1`.
  - `mem_ack & ~flush`: push `mem_rdata`, go to IDLE.
  - `mem_ack & flush`: discard the word, clear the buffer, go to IDLE.
  - `flush & ~mem_ack`: clear the buffer, go to DROP.
  - Otherwise stay in REQ.
- **DROP:**
  - `mem_req=1` with `mem_addr` unchanged; the protocol forbids abandoning a request.
  - `mem_ack`: discard the word, go to IDLE.
  - `flush` in DROP has no additional effect.
- **`stahp`:** combinational, `stahp = ~(state==IDLE & count<2 & ~flush)`. Forced to 1 while `reset` is low.
- **Buffer:**
  - 2-entry FIFO with 1-bit read and write pointers that wrap modulo 2, and a 2-bit `count` (0..2).
  - `ir` = head entry; `ir_valid = (count!=0)`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Overflow is impossible: a request is only issued when `count<2`, and only one request is outstanding.
  - A pop with `count==0` is ignored.
  - `flush` overrides both push and pop: `count` becomes 0 and the pointers return to 0 on that edge.
- **Ignored inputs:** `mem_ack` while `mem_req` is low is ignored. `mem_rdata` is only sampled on an accepted ack.
- **Reset values** (while `reset` is low):
  - state = IDLE, `count=0`, pointers = 0.
  - `mem_req=0`, `mem_addr=0`.
  - `ir_valid=0`, `ir=0`, `stahp=1`.
- **Reset during REQ or DROP:** the request is dropped immediately. A later stray `mem_ack` is ignored because `mem_req=0`.

## Timing

- A fetch is accepted in cycle N (IDLE, `stahp=0`), and `pc_addr` is registered at the end of N.
- `mem_req` goes high from cycle N+1.
- An ack in cycle M (M ≥ N+1) gives `ir_valid=1` from cycle M+1 if the buffer was empty.
- With a zero-wait memory (ack in the first REQ cycle), throughput is one instruction per 2 cycles and `stahp` alternates 0/1.
- The next fetch can be accepted in cycle M+1.
- `flush` takes effect at the edge ending its cycle. From the next cycle `ir_valid=0`, and no pre-flush word ever reaches `ir`.
- The first post-flush fetch captures `pc_addr` one cycle after `flush` if the FSM is in IDLE, otherwise one cycle after the DROP ack.

## Test plan

- **Reset:** hold `reset=0` for 2 cycles → `stahp=1`, `mem_req=0`, `ir_valid=0`. Release with `pc_addr=16'h0000` → `stahp=0` in the first cycle, then `mem_req=1`, `mem_addr=16'h0000`.
- **Zero-wait stream:** PC supplies 0000, 0001, 0002; memory acks immediately with AAAA, 1234, A1A1; `ir_ready=1` → `ir` shows AAAA, 1234, A1A1 in order, each valid from the cycle after its ack.
- **Backpressure:** `ir_ready=0`, two fetches complete → `count=2`, `stahp` held 1, `mem_req=0`. Raise `ir_ready` for one cycle → one pop, then the next fetch is accepted the following cycle.
- **Flush in REQ:** ack delayed by 3 cycles; assert `flush` in the 2nd wait cycle → FSM enters DROP with `mem_req` still high. The late word (e.g. 16'hDEAD) is discarded, `ir_valid` stays 0, and the next `mem_addr` equals the post-flush `pc_addr` (16'hA1A1).
- **Simultaneous events:**
  - `flush` in the same cycle as `mem_ack` → word discarded, IDLE next cycle.
  - Push with pop at `count=1` → `count` stays 1.
- **Reset mid-REQ:** `reset` pulsed low while `mem_req=1` → `mem_req` drops immediately. A subsequent `mem_ack` is ignored and `ir_valid` stays 0.
